// File: rtl/redmule_tcdm_splitter.sv
// Wide-to-narrow TCDM splitter for RedMulE.
// One wide request is fanned out to MP 32-bit bank ports. Each lane is granted
// on its own schedule and the wide grant fires only once every lane is done.
// Lane responses are buffered per lane and re-assembled into one aligned
// wide response.

// Per-lane response buffer with an empty-bypass path.
module redmule_tcdm_splitter_lane #(
  parameter int unsigned MEMDW  = 32,
  parameter int unsigned RDEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             r_valid_i,
  input  logic [MEMDW-1:0] r_data_i,
  input  logic             pop_i,
  output logic             avail_o,
  output logic [MEMDW-1:0] head_o,
  output logic             nempty_o,
  output logic             ovf_o
);
  localparam int unsigned PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int unsigned CW = $clog2(RDEPTH + 1);

  logic [RDEPTH-1:0][MEMDW-1:0] mem;
  logic [PW-1:0]                rptr, wptr;
  logic [CW-1:0]                cnt;
  logic                         empty, full, pop_q, push, wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(RDEPTH));
  assign nempty_o = ~empty;
  assign avail_o  = ~empty | r_valid_i;
  // With an empty buffer the incoming beat goes straight to the aligner.
  assign head_o   = empty ? r_data_i : mem[rptr];
  assign pop_q    = pop_i & ~empty;
  // A beat consumed through the bypass is never stored.
  assign push     = r_valid_i & ~(empty & pop_i);
  // Full and not draining this cycle: the beat has nowhere to go.
  assign ovf_o    = push & full & ~pop_i;
  assign wr       = push & ~ovf_o;

  // Buffer storage; contents are don't-care until counted valid.
  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= r_data_i;
  end

  // Pointer and occupancy bookkeeping; reset flushes the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)    wptr <= nxt(wptr);
      if (pop_q) rptr <= nxt(rptr);
      case ({wr, pop_q})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module redmule_tcdm_splitter #(
  parameter int unsigned MP     = 8,
  parameter int unsigned MEMDW  = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned RDEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [AW-1:0]       add_i,
  input  logic                wen_i,
  input  logic [MP*4-1:0]     be_i,
  input  logic [MP*MEMDW-1:0] data_i,
  output logic [MP*MEMDW-1:0] r_data_o,
  output logic                r_valid_o,
  output logic [MP-1:0]       tcdm_req_o,
  input  logic [MP-1:0]       tcdm_gnt_i,
  output logic [MP*AW-1:0]    tcdm_add_o,
  output logic [MP-1:0]       tcdm_wen_o,
  output logic [MP*4-1:0]     tcdm_be_o,
  output logic [MP*MEMDW-1:0] tcdm_data_o,
  input  logic [MP*MEMDW-1:0] tcdm_r_data_i,
  input  logic [MP-1:0]       tcdm_r_valid_i,
  output logic                busy_o,
  output logic                err_o
);
  logic                         req_g, all_avail;
  logic [MP-1:0]                done, avail, nempty, ovf;
  logic [MP-1:0][MEMDW-1:0]     head;

  // Requests are masked while reset is held so nothing leaks to the banks.
  assign req_g      = req_i & ~rst_i;
  assign tcdm_req_o = {MP{req_g}} & ~done;
  assign gnt_o      = req_g & (&(done | tcdm_gnt_i));
  assign all_avail  = &avail;
  assign busy_o     = req_g | (|done) | (|nempty) | r_valid_o;

  for (genvar i = 0; i < MP; i++) begin : g_lane
    // Lane address wraps modulo 2^AW.
    assign tcdm_add_o[AW*i +: AW]       = add_i + AW'(4 * i);
    assign tcdm_wen_o[i]                = wen_i;
    assign tcdm_be_o[4*i +: 4]          = be_i[4*i +: 4];
    assign tcdm_data_o[MEMDW*i +: MEMDW] = data_i[MEMDW*i +: MEMDW];

    redmule_tcdm_splitter_lane #(
      .MEMDW  (MEMDW),
      .RDEPTH (RDEPTH)
    ) i_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .r_valid_i (tcdm_r_valid_i[i]),
      .r_data_i  (tcdm_r_data_i[MEMDW*i +: MEMDW]),
      .pop_i     (all_avail),
      .avail_o   (avail[i]),
      .head_o    (head[i]),
      .nempty_o  (nempty[i]),
      .ovf_o     (ovf[i])
    );
  end

  // Track which lanes have already been granted in the current wide request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      done <= '0;
    else if (gnt_o) done <= '0;
    else            done <= done | (tcdm_req_o & tcdm_gnt_i);
  end

  // Aligned response register plus sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      r_valid_o <= all_avail;
      if (all_avail) r_data_o <= head;
      if (|ovf)      err_o    <= 1'b1;
    end
  end
endmodule
